// File: rtl/alif_multichannel_neuron_if.sv
// Pin bundle of the multi-channel ALIF neuron: run control, channel inputs,
// serial configuration port and the registered neuron outputs.
interface alif_multichannel_neuron_if #(
  parameter int N_CH = 4,
  parameter int IN_W = 6,
  parameter int V_W  = 8
);
  logic                 enable;
  logic                 input_enable;
  logic [N_CH*IN_W-1:0] chan_in;
  logic                 load_mode;
  logic                 serial_data;
  logic                 spike_out;
  logic [V_W-1:0]       v_mem_out;
  logic                 params_ready;

  modport master (
    output enable, input_enable, chan_in, load_mode, serial_data,
    input  spike_out, v_mem_out, params_ready
  );

  modport slave (
    input  enable, input_enable, chan_in, load_mode, serial_data,
    output spike_out, v_mem_out, params_ready
  );
endinterface

// File: rtl/alif_multichannel_neuron.sv
// ALIF neuron, N_CH weighted channels, serial config frame, refractory period; outputs 1 cycle after the sampling edge,
// no backpressure (state simply holds while not running). ALIF_ADAPT_EN adds the adaptive threshold.
module alif_multichannel_neuron #(
  parameter int N_CH = 4,
  parameter int IN_W = 6,
  parameter int W_W  = 4,
  parameter int V_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  alif_multichannel_neuron_if.slave bus
);
  localparam int NW    = N_CH * W_W;
  localparam int F     = V_W + 14 + NW;
  localparam int CNT_W = $clog2(F + 1);
  localparam int SYN_W = IN_W + W_W + 1 + $clog2(N_CH);
  localparam int VN_W  = ((SYN_W > V_W + 1) ? SYN_W : V_W + 1) + 1;
  localparam logic [CNT_W-1:0] F_C    = CNT_W'(F);
  localparam logic [CNT_W-1:0] F_LAST = CNT_W'(F - 1);
  localparam logic [V_W-1:0]   V_MAX  = '1;

  typedef enum logic [1:0] {ST_LOAD, ST_IDLE, ST_INTEGRATE, ST_REFRAC} state_t;

  logic             load_q, load_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [F-2:0]     shadow_q, shadow_d;
  logic             ready_q, ready_d;
  logic [V_W-1:0]   thr_q, thr_d;
  logic [2:0]       leak_q, leak_d;
  logic [3:0]       refl_q, refl_d;
  logic [NW-1:0]    w_q, w_d;
  logic [V_W-1:0]   v_q, v_d;
  logic [3:0]       refrac_q, refrac_d;
  logic             spike_q, spike_d;
`ifdef ALIF_ADAPT_EN
  logic [3:0]       ainc_q, ainc_d;
  logic [2:0]       ashift_q, ashift_d;
  logic [V_W-1:0]   adapt_q, adapt_d;
  logic [V_W-1:0]   decay;
  logic [V_W:0]     adapt_sum;
`else
  logic             unused_adapt_fields;
`endif

  logic [F-1:0]            frame;
  logic [CNT_W-1:0]        cnt_base;
  logic                    run;
  state_t                  state;
  logic signed [SYN_W-1:0] syn;
  logic [V_W-1:0]          leaked;
  logic [V_W-1:0]          v_next;
  logic signed [VN_W-1:0]  v_sum;
  logic [V_W:0]            theta;

  // The bit arriving this cycle completes the frame, so the shadow only keeps F-1 bits.
  assign frame    = {shadow_q, bus.serial_data};
  assign cnt_base = (bus.load_mode && !load_q) ? '0 : cnt_q;
  assign run      = bus.enable & bus.input_enable & ready_q & ~bus.load_mode;
`ifndef ALIF_ADAPT_EN
  assign unused_adapt_fields = ^frame[NW+10:NW+4];
`endif

  always_comb begin
    syn = '0;
    for (int i = 0; i < N_CH; i++) begin
      syn = syn + $signed({{(SYN_W-IN_W){1'b0}}, bus.chan_in[i*IN_W +: IN_W]})
                * $signed({{(SYN_W-W_W){w_q[i*W_W+W_W-1]}}, w_q[i*W_W +: W_W]});
    end
  end

  always_comb begin
    leaked = v_q - (v_q >> leak_q);
    v_sum  = $signed({{(VN_W-V_W){1'b0}}, leaked}) + $signed({{(VN_W-SYN_W){syn[SYN_W-1]}}, syn});
    if (v_sum[VN_W-1])
      v_next = '0;
    else if (v_sum > $signed({{(VN_W-V_W){1'b0}}, V_MAX}))
      v_next = V_MAX;
    else
      v_next = v_sum[V_W-1:0];
`ifdef ALIF_ADAPT_EN
    decay     = adapt_q - (adapt_q >> ashift_q);
    adapt_sum = {1'b0, decay} + {{(V_W-3){1'b0}}, ainc_q};
    theta     = {1'b0, thr_q} + {1'b0, adapt_q};
`else
    theta     = {1'b0, thr_q};
`endif
    if (!bus.enable)              state = ST_IDLE;
    else if (bus.load_mode)       state = ST_LOAD;
    else if (!run)                state = ST_IDLE;
    else if (refrac_q != 4'd0)    state = ST_REFRAC;
    else                          state = ST_INTEGRATE;
  end

  always_comb begin
    load_d   = load_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    ready_d  = ready_q;
    thr_d    = thr_q;
    leak_d   = leak_q;
    refl_d   = refl_q;
    w_d      = w_q;
    v_d      = v_q;
    refrac_d = refrac_q;
    spike_d  = 1'b0;
`ifdef ALIF_ADAPT_EN
    ainc_d   = ainc_q;
    ashift_d = ashift_q;
    adapt_d  = adapt_q;
`endif
    if (bus.enable) begin
      load_d = bus.load_mode;
      if (bus.load_mode && !load_q) ready_d = 1'b0;
      // Counter parks at F so trailing bits are dropped until load_mode falls.
      if (bus.load_mode && cnt_base != F_C) begin
        shadow_d = frame[F-2:0];
        cnt_d    = cnt_base + CNT_W'(1);
        if (cnt_base == F_LAST) begin
          ready_d  = 1'b1;
          thr_d    = frame[F-1 -: V_W];
          leak_d   = frame[NW+13 -: 3];
          refl_d   = frame[NW+3 -: 4];
          w_d      = frame[NW-1:0];
`ifdef ALIF_ADAPT_EN
          ainc_d   = frame[NW+10 -: 4];
          ashift_d = frame[NW+6 -: 3];
`endif
        end
      end
    end

    case (state)
      ST_REFRAC: begin
        v_d      = '0;
        refrac_d = refrac_q - 4'd1;
`ifdef ALIF_ADAPT_EN
        adapt_d  = decay;
`endif
      end
      ST_INTEGRATE: begin
        if ({1'b0, v_next} >= theta) begin
          spike_d  = 1'b1;
          v_d      = '0;
          refrac_d = refl_q;
`ifdef ALIF_ADAPT_EN
          adapt_d  = adapt_sum[V_W] ? V_MAX : adapt_sum[V_W-1:0];
`endif
        end else begin
          v_d      = v_next;
`ifdef ALIF_ADAPT_EN
          adapt_d  = decay;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q   <= 1'b0;
      cnt_q    <= '0;
      shadow_q <= '0;
      ready_q  <= 1'b0;
      thr_q    <= '0;
      leak_q   <= '0;
      refl_q   <= '0;
      w_q      <= '0;
      v_q      <= '0;
      refrac_q <= '0;
      spike_q  <= 1'b0;
`ifdef ALIF_ADAPT_EN
      ainc_q   <= '0;
      ashift_q <= '0;
      adapt_q  <= '0;
`endif
    end else begin
      load_q   <= load_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      ready_q  <= ready_d;
      thr_q    <= thr_d;
      leak_q   <= leak_d;
      refl_q   <= refl_d;
      w_q      <= w_d;
      v_q      <= v_d;
      refrac_q <= refrac_d;
      spike_q  <= spike_d;
`ifdef ALIF_ADAPT_EN
      ainc_q   <= ainc_d;
      ashift_q <= ashift_d;
      adapt_q  <= adapt_d;
`endif
    end
  end

  assign bus.spike_out    = spike_q;
  assign bus.v_mem_out    = v_q;
  assign bus.params_ready = ready_q;
endmodule

// File: tb/tb_alif_multichannel_neuron.sv
// Scoreboard bench for alif_multichannel_neuron: a frame-level reference model predicts every
// cycle's outputs; a monitor compares them one cycle later.
module tb_alif_multichannel_neuron;
  localparam int N_CH = 4;
  localparam int IN_W = 6;
  localparam int W_W  = 4;
  localparam int V_W  = 8;
  localparam int F    = V_W + 3 + 4 + 3 + 4 + N_CH*W_W;
  localparam int VMAX = (1 << V_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alif_multichannel_neuron_if #(.N_CH(N_CH), .IN_W(IN_W), .V_W(V_W)) bus();

  alif_multichannel_neuron #(.N_CH(N_CH), .IN_W(IN_W), .W_W(W_W), .V_W(V_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic           spike;
    logic [V_W-1:0] v;
    logic           ready;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   chan[N_CH];
  int   wts[N_CH];

  // Reference model state
  int     m_v, m_adapt, m_refrac, m_cnt;
  bit     m_spike, m_ready, m_prev_load;
  longint unsigned m_shadow;
  int     p_thr, p_leak, p_ainc, p_ashift, p_refl;
  int     p_w[N_CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  task automatic decode_frame(input longint unsigned fr);
    longint unsigned f;
    int b;
    f = fr;
    for (int i = 0; i < N_CH; i++) begin
      b = int'(f & 64'd15);
      p_w[i] = (b >= 8) ? b - 16 : b;
      f = f >> 4;
    end
    p_refl   = int'(f & 64'd15); f = f >> 4;
    p_ashift = int'(f & 64'd7);  f = f >> 3;
    p_ainc   = int'(f & 64'd15); f = f >> 4;
    p_leak   = int'(f & 64'd7);  f = f >> 3;
    p_thr    = int'(f & 64'(VMAX));
  endtask

  task automatic model_step(input bit en, input bit ie, input bit lm, input bit sd, input bit rs);
    int  syn, vn, decay, theta, sum;
    bit  run;
    if (rs) begin
      m_v = 0; m_adapt = 0; m_refrac = 0; m_cnt = 0; m_spike = 0; m_ready = 0;
      m_prev_load = 0; m_shadow = 0;
      p_thr = 0; p_leak = 0; p_ainc = 0; p_ashift = 0; p_refl = 0;
      for (int i = 0; i < N_CH; i++) p_w[i] = 0;
      return;
    end
    m_spike = 0;
    if (!en) return;
    run = ie && m_ready && !lm;
    if (lm) begin
      if (!m_prev_load) begin
        m_cnt = 0;
        m_ready = 0;
      end
      if (m_cnt < F) begin
        m_shadow = (m_shadow << 1) | longint'(sd);
        m_cnt++;
        if (m_cnt == F) begin
          decode_frame(m_shadow);
          m_ready = 1;
        end
      end
    end
    m_prev_load = lm;
    if (run) begin
      syn = 0;
      for (int i = 0; i < N_CH; i++) syn += chan[i] * p_w[i];
      vn = m_v - (m_v >> p_leak) + syn;
      if (vn < 0) vn = 0;
      if (vn > VMAX) vn = VMAX;
`ifdef ALIF_ADAPT_EN
      decay = m_adapt - (m_adapt >> p_ashift);
      theta = p_thr + m_adapt;
`else
      decay = 0;
      theta = p_thr;
`endif
      if (m_refrac != 0) begin
        m_v = 0; m_refrac--; m_adapt = decay;
      end else if (vn >= theta) begin
        m_spike = 1; m_v = 0; m_refrac = p_refl;
        sum = decay + p_ainc;
        m_adapt = (sum > VMAX) ? VMAX : sum;
      end else begin
        m_v = vn; m_adapt = decay;
      end
    end
  endtask

  task automatic drive(input bit en, input bit ie, input bit lm, input bit sd, input bit rs);
    exp_t e;
    @(negedge clk);
    reset            = rs;
    bus.enable       = en;
    bus.input_enable = ie;
    bus.load_mode    = lm;
    bus.serial_data  = sd;
    for (int i = 0; i < N_CH; i++) bus.chan_in[i*IN_W +: IN_W] = IN_W'(chan[i]);
    model_step(en, ie, lm, sd, rs);
    e.spike = m_spike;
    e.v     = V_W'(m_v);
    e.ready = m_ready;
    exp_q.push_back(e);
  endtask

  task automatic load_frame(input int thr, input int leak, input int ainc, input int ashift,
                            input int refl, input int nbits, input bit ie);
    longint unsigned fr;
    int pos;
    bit b;
    fr = longint'(thr & VMAX);
    fr = (fr << 3) | longint'(leak & 7);
    fr = (fr << 4) | longint'(ainc & 15);
    fr = (fr << 3) | longint'(ashift & 7);
    fr = (fr << 4) | longint'(refl & 15);
    for (int i = N_CH - 1; i >= 0; i--) fr = (fr << 4) | longint'(wts[i] & 15);
    for (int k = 0; k < nbits; k++) begin
      pos = F - 1 - k;
      b = (pos >= 0) ? fr[pos] : 1'($urandom_range(0, 1));
      drive(1'b1, ie, 1'b1, b, 1'b0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rand_weights();
    for (int i = 0; i < N_CH; i++) wts[i] = int'($urandom_range(0, 15)) - 8;
  endtask

  task automatic rand_chans();
    for (int i = 0; i < N_CH; i++) chan[i] = int'($urandom_range(0, 63));
  endtask

  // Monitor: every cycle the DUT presents a fresh registered output.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("spike_out",    32'(bus.spike_out),    32'(e.spike));
        check("v_mem_out",    32'(bus.v_mem_out),    32'(e.v));
        check("params_ready", 32'(bus.params_ready), 32'(e.ready));
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, thr, n;
    reset = 1'b1;
    bus.enable = 1'b0; bus.input_enable = 1'b0; bus.load_mode = 1'b0;
    bus.serial_data = 1'b0; bus.chan_in = '0;
    for (int i = 0; i < N_CH; i++) begin chan[i] = 0; wts[i] = 0; end

    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    rand_chans();
    run_cycles(5);

    // Integration, refractory and adaptation frames with w0=+1, chan0=10
    wts = '{1, 0, 0, 0};
    load_frame(50, 7, 0, 0, 0, F, 1'b1);
    chan = '{10, 0, 0, 0};
    run_cycles(12);
    load_frame(50, 7, 0, 0, 3, F, 1'b1);
    run_cycles(20);
    load_frame(50, 7, 8, 7, 0, F, 1'b1);
    run_cycles(25);

    // Saturation both ways
    wts = '{-8, -8, -8, -8};
    chan = '{63, 63, 63, 63};
    load_frame(50, 7, 0, 0, 0, F, 1'b1);
    run_cycles(6);
    wts = '{7, 7, 7, 7};
    load_frame(255, 7, 0, 0, 0, F, 1'b1);
    run_cycles(4);

    // Aborted load freezes the neuron until a complete frame arrives
    wts = '{1, 0, 0, 0};
    chan = '{10, 0, 0, 0};
    load_frame(50, 7, 0, 0, 0, F, 1'b1);
    run_cycles(3);
    load_frame(30, 7, 0, 0, 0, 20, 1'b1);
    run_cycles(5);
    load_frame(30, 7, 0, 0, 0, F, 1'b1);
    run_cycles(8);
    load_frame(20, 1, 0, 0, 1, F + 5, 1'b1);
    run_cycles(8);

    // Global enable low holds everything
    repeat (4) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_cycles(3);

    // Reset mid-refractory and mid-load
    wts = '{7, 7, 7, 7};
    chan = '{63, 63, 63, 63};
    load_frame(100, 7, 0, 0, 15, F, 1'b1);
    run_cycles(3);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    run_cycles(3);
    load_frame(100, 7, 0, 0, 0, 10, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    run_cycles(3);

    // Randomized traffic
    for (int it = 0; it < 1500; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
      end else if (r < 8) begin
        rand_weights();
        thr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 60));
        n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, F + 4)) : F;
        load_frame(thr, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), n,
                   1'($urandom_range(0, 1)));
      end else begin
        rand_chans();
        drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) != 0), 1'b0, 1'b0, 1'b0);
      end
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/alif_multichannel_neuron.md
# alif_multichannel_neuron

Parametrised adaptive leaky integrate-and-fire (ALIF) neuron with N_CH weighted input channels, serially loaded configuration and a refractory period. It is the multi-channel successor of the single-channel ALIF system and sits directly behind the TinyTapeout pin wrapper. It accumulates weighted channel inputs into a saturating membrane potential and fires when that potential reaches an adaptive threshold.

## Interface
- N_CH, 4: number of input channels (1..8).
- IN_W, 6: unsigned input width per channel.
- W_W, 4: signed two's-complement weight width.
- V_W, 8: membrane potential, threshold and adaptation width (unsigned).
- clk  in  1  clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  global enable; when low, all state holds and `spike_out` is 0.
- input_enable  in  1  neuron update enable.
- chan_in  in  N_CH*IN_W  channel i is at [i*IN_W +: IN_W].
- load_mode  in  1  configuration shift mode.
- serial_data  in  1  configuration bit, MSB-first.
- spike_out  out  1  registered one-cycle spike pulse.
- v_mem_out  out  V_W  registered membrane potential.
- params_ready  out  1  a complete configuration frame is committed.

## Operation
- Frame length F = V_W + 3 + 4 + 3 + 4 + N_CH*W_W (38 bits at defaults).
- Frame fields, MSB to LSB:
  - threshold[V_W]
  - leak_shift[3]
  - adapt_inc[4]
  - adapt_shift[3]
  - refrac_len[4]
  - w[N_CH-1] .. w[0]
- Loading:
  - On the cycle `load_mode` rises: bit counter is cleared and `params_ready` goes to 0.
  - Each cycle with `load_mode`=1: `serial_data` shifts into the shadow register and the counter increments.
  - On the F-th bit: the shadow register is committed to the active parameters and `params_ready` goes to 1 on the same edge.
  - Bits after the F-th are ignored until `load_mode` falls.
  - Abort (`load_mode` falls before F bits): shadow contents are discarded, the active parameters are unchanged, and `params_ready` stays 0 until a complete load.
- run = enable & input_enable & params_ready & ~load_mode. When run=0, `v`, `adapt` and `refrac` hold and `spike_out`=0.
- Per run cycle:
  - syn = Σ chan_i*w_i, signed, full precision: IN_W+W_W+1+clog2(N_CH) bits.
  - v_next = v − (v >> leak_shift) + syn, clamped to [0, 2^V_W−1].
  - decay = adapt − (adapt >> adapt_shift).
  - theta = threshold + adapt, computed in V_W+1 bits with no wrap.
  - If refrac≠0: v←0, refrac←refrac−1, adapt←decay, no spike.
  - Else if v_next ≥ theta: spike_out←1, v←0, refrac←refrac_len, adapt←min(decay + adapt_inc, 2^V_W−1).
  - Else: v←v_next, adapt←decay.
- threshold=0 fires on every non-refractory run cycle.
- Internal states: LOAD (load_mode=1), IDLE (run=0), INTEGRATE, REFRACTORY (refrac≠0). Transitions follow the rules above.

## Timing
- All outputs are registered.
- Reset values: `spike_out`=0, `v_mem_out`=0, `params_ready`=0. v, adapt, refrac, bit counter, shadow register and all parameters reset to 0.
- Latency: inputs sampled at edge t are reflected in `spike_out`/`v_mem_out` after edge t (1 cycle).
- `spike_out` is a single-cycle pulse. At `refrac_len`=0, consecutive spikes can occur on back-to-back cycles.
- Reset asserted mid-load or mid-refractory: all state clears immediately; a full reload is required.
- Simultaneous `load_mode` rise and run condition: load wins (run=0 that cycle).

## Configuration
- Macro: ALIF_ADAPT_EN.
- Defined: adaptive threshold exactly as specified under Operation.
- Undefined: the adapt register is absent and theta = threshold. The adapt_inc and adapt_shift frame fields are still shifted in, so the frame length is unchanged, but they are ignored.

## Test plan
All cases use default parameters.

- Reset: assert `reset` at any point → all outputs 0; with `input_enable`=1 and no load, `v_mem_out` stays 0.
- Integration: load threshold=50, leak_shift=7, adapt_inc=0, adapt_shift=0, refrac_len=0, w0=+1, others 0; chan0=10, others 0 → `v_mem_out` reads 10, 20, 30, 40; spike on the 5th run cycle; then 10 again.
- Refractory: same frame with refrac_len=3 → after each spike `v_mem_out`=0 for 3 cycles; spikes every 8 run cycles.
- Adaptation: refrac_len=0, adapt_inc=8, adapt_shift=7 → with ALIF_ADAPT_EN, 2nd spike comes 6 cycles after the 1st (theta 58) and the 3rd comes 7 cycles after the 2nd (theta 66); without the macro, the period stays 5.
- Saturation:
  - All weights −8, all chans=63 → `v_mem_out` stays 0, no spikes.
  - All weights +7, all chans=63, threshold=255, leak_shift=7, adapt_inc=0 → v_next clamps to 255 and fires on the first run cycle.
- Aborted load: after a valid load, raise `load_mode` for 20 bits then drop it → `params_ready`=0 and the neuron is frozen; a subsequent full 38-bit load → `params_ready`=1 on the 38th edge.
